hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline (IF/ID/EX/ME/WB).
//  - Detects load-use hazards and stalls PC/IF-ID while injecting bubbles into ID/EX.
//  - Flushes younger stages on a branch/jump redirect resolved in ME.
//  - Drives EX-stage forwarding selects and runs a halt/drain FSM for external memory access.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard sequencer for a 5-stage IF/ID/EX/ME/WB pipeline.
//                Load-use stall insertion, redirect flushing, EX-stage
//                forwarding selects, halt/drain FSM and saturating
//                stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_waddr,
  input  logic             me_mem_read,
  input  logic             me_reg_write,
  input  logic [4:0]       me_waddr,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_waddr,
  input  logic             me_redirect,
  input  logic             halt_req,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_me_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The drain counter is 3 bits wide, so at most 8 drain cycles are possible.
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] dcnt;
  logic [2:0] dcnt_nxt;

  logic       dep_ex;
  logic       dep_me;
  logic       lu;
  logic       stall_evt;
  logic       flush_evt;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // Forward source select for one EX operand; the ME result wins over WB and
  // a load in ME has no ALU result to forward yet.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       me_rw,
    input logic       me_mr,
    input logic [4:0] me_wa,
    input logic       wb_rw,
    input logic [4:0] wb_wa
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (me_rw && !me_mr && (me_wa != 5'd0) && (me_wa == src)) begin
      sel = 2'b01;
    end else if (wb_rw && (wb_wa != 5'd0) && (wb_wa == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // True when the ID instruction reads register r (never for $0).
  function automatic logic dep(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  // Load-use detection: a load in EX or ME whose result the ID instruction needs.
  always_comb begin
    dep_ex    = dep(ex_waddr, id_rs, id_rt, id_uses_rt);
    dep_me    = dep(me_waddr, id_rs, id_rt, id_uses_rt);
    lu        = (ex_mem_read & ex_reg_write & dep_ex) |
                (me_mem_read & me_reg_write & dep_me);
    fwd_a_raw = fwd_sel(ex_rs, me_reg_write, me_mem_read, me_waddr,
                        wb_reg_write, wb_waddr);
    fwd_b_raw = fwd_sel(ex_rt, me_reg_write, me_mem_read, me_waddr,
                        wb_reg_write, wb_waddr);
  end

  // A stall only exists while fetching; a redirect supersedes it.
  assign stall_evt = enable & lu & ~me_redirect & (state == ST_RUN);
  assign flush_evt = enable & me_redirect;

  // FSM state and drain counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_RUN;
      dcnt  <= 3'd0;
    end else if (enable) begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next-state logic and pipeline control outputs.
  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    halted      = (state == ST_HALTED);

    unique case (state)
      ST_RUN: begin
        // Any pending stall or redirect is allowed to finish before draining.
        if (halt_req && !lu && !me_redirect) begin
          state_nxt = ST_DRAIN;
          dcnt_nxt  = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end else if (dcnt == 3'd0) begin
          state_nxt = ST_HALTED;
        end else begin
          dcnt_nxt = dcnt - 3'd1;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (enable) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (state != ST_RUN) begin
        // Fetch is stopped: keep the PC and feed NOPs into IF/ID.
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
      end
      if (me_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        ex_me_flush = 1'b1;
      end else if (stall_evt) begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (directed table,
//                corner-case sequences, randomized run against a model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int DRAIN_CYC = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable, id_uses_rt, ex_mem_read, ex_reg_write;
  logic        me_mem_read, me_reg_write, wb_reg_write, me_redirect, halt_req;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_waddr, me_waddr, wb_waddr;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_me_flush, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pc_hold, s_if_id_hold, s_if_id_flush, s_id_ex_flush, s_ex_me_flush, s_halted;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32), .DRAIN_CYC(DRAIN_CYC)) u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_waddr(ex_waddr),
    .me_mem_read(me_mem_read), .me_reg_write(me_reg_write), .me_waddr(me_waddr),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr),
    .me_redirect(me_redirect), .halt_req(halt_req),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(DRAIN_CYC)) u_small (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_waddr(ex_waddr),
    .me_mem_read(me_mem_read), .me_reg_write(me_reg_write), .me_waddr(me_waddr),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr),
    .me_redirect(me_redirect), .halt_req(halt_req),
    .pc_hold(s_pc_hold), .if_id_hold(s_if_id_hold), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .ex_me_flush(s_ex_me_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_wa;
    logic       me_mr;
    logic       me_rw;
    logic [4:0] me_wa;
    logic       wb_rw;
    logic [4:0] wb_wa;
    logic       redir;
    logic       e_pc;
    logic       e_ifh;
    logic       e_iff;
    logic       e_ief;
    logic       e_emf;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  vec_t vecs [11];

  // ---------------- reference model ----------------
  int m_mode;      // 0 fetching, 1 draining, 2 halted
  int m_drained;   // drain cycles already spent
  int m_stalls;
  int m_flushes;

  function automatic bit reads_reg(input int r);
    return r != 0 && (r == id_rs || (id_uses_rt && r == id_rt));
  endfunction

  function automatic bit m_lu();
    return (ex_mem_read && ex_reg_write && reads_reg(ex_waddr)) ||
           (me_mem_read && me_reg_write && reads_reg(me_waddr));
  endfunction

  function automatic int m_fwd(input int src);
    if (src == 0) return 0;
    if (me_reg_write && !me_mem_read && me_waddr == src) return 1;
    if (wb_reg_write && wb_waddr == src) return 2;
    return 0;
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drained = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_clock();
    bit l;
    l = m_lu();
    if (!enable) return;
    if (l && !me_redirect && m_mode == 0) m_stalls++;
    if (me_redirect) m_flushes++;
    if (m_mode == 0) begin
      if (halt_req && !l && !me_redirect) begin m_mode = 1; m_drained = 0; end
    end else if (m_mode == 1) begin
      m_drained++;
      if (!halt_req) m_mode = 0;
      else if (m_drained == DRAIN_CYC) m_mode = 2;
    end else begin
      if (!halt_req) m_mode = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_waddr = 5'd0;
    me_mem_read = 1'b0; me_reg_write = 1'b0; me_waddr = 5'd0;
    wb_reg_write = 1'b0; wb_waddr = 5'd0; me_redirect = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    #2 arst_n = 1'b0;
    model_reset();
    #3;
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Compare every output of both instances against the model.
  task automatic check_model(input string tag);
    bit l, st, run;
    l   = m_lu();
    run = (m_mode == 0);
    st  = enable && l && !me_redirect && run;
    chk({tag, "_pc_hold"},  64'(pc_hold),     64'(enable && (!run || st)));
    chk({tag, "_ifid_hold"}, 64'(if_id_hold), 64'(st));
    chk({tag, "_ifid_flush"}, 64'(if_id_flush), 64'(enable && (!run || me_redirect)));
    chk({tag, "_idex_flush"}, 64'(id_ex_flush), 64'(enable && (me_redirect || st)));
    chk({tag, "_exme_flush"}, 64'(ex_me_flush), 64'(enable && me_redirect));
    chk({tag, "_fwd_a"}, 64'(fwd_a), enable ? 64'(m_fwd(ex_rs)) : 64'd0);
    chk({tag, "_fwd_b"}, 64'(fwd_b), enable ? 64'(m_fwd(ex_rt)) : 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'(m_mode == 2));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stalls));
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flushes));
    chk({tag, "_s_pc_hold"}, 64'(s_pc_hold), 64'(pc_hold == 1'b1 ? 1 : 0) & 64'(enable && (!run || st)));
    chk({tag, "_s_halted"}, 64'(s_halted), 64'(m_mode == 2));
    chk({tag, "_s_stall_cnt"}, 64'(s_stall_cnt), 64'(sat4(m_stalls)));
    chk({tag, "_s_flush_cnt"}, 64'(s_flush_cnt), 64'(sat4(m_flushes)));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    //        id_rs id_rt  urt  ex_rs  ex_rt  emr  erw  ex_wa  mmr  mrw  me_wa  wrw  wb_wa redir pc   ifh  iff  ief  emf  fa     fb
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[1]  = '{5'd2, 5'd4, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[2]  = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[3]  = '{5'd1, 5'd2, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[4]  = '{5'd3, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[5]  = '{5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
    vecs[9]  = '{5'd2, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[10] = '{5'd2, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};

    do_reset();

    // ---- directed table (fetching state, enable=1, no halt request) ----
    for (int i = 0; i < 11; i++) begin
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_uses_rt = vecs[i].id_uses_rt;
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
      ex_mem_read = vecs[i].ex_mr; ex_reg_write = vecs[i].ex_rw; ex_waddr = vecs[i].ex_wa;
      me_mem_read = vecs[i].me_mr; me_reg_write = vecs[i].me_rw; me_waddr = vecs[i].me_wa;
      wb_reg_write = vecs[i].wb_rw; wb_waddr = vecs[i].wb_wa; me_redirect = vecs[i].redir;
      #2;
      chk($sformatf("vec%0d_pc_hold", i), 64'(pc_hold), 64'(vecs[i].e_pc));
      chk($sformatf("vec%0d_ifid_hold", i), 64'(if_id_hold), 64'(vecs[i].e_ifh));
      chk($sformatf("vec%0d_ifid_flush", i), 64'(if_id_flush), 64'(vecs[i].e_iff));
      chk($sformatf("vec%0d_idex_flush", i), 64'(id_ex_flush), 64'(vecs[i].e_ief));
      chk($sformatf("vec%0d_exme_flush", i), 64'(ex_me_flush), 64'(vecs[i].e_emf));
      chk($sformatf("vec%0d_fwd_a", i), 64'(fwd_a), 64'(vecs[i].e_fa));
      chk($sformatf("vec%0d_fwd_b", i), 64'(fwd_b), 64'(vecs[i].e_fb));
      tick();
    end

    // ---- load-use: two bubbles, then WB forward ----
    idle_inputs(); do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_waddr = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    #2 chk("lu1_pc_hold", 64'(pc_hold), 64'd1);
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_waddr = 5'd0;
    me_mem_read = 1'b1; me_reg_write = 1'b1; me_waddr = 5'd2;
    #2 chk("lu2_id_ex_flush", 64'(id_ex_flush), 64'd1);
    tick();
    idle_inputs();
    wb_reg_write = 1'b1; wb_waddr = 5'd2; ex_rs = 5'd2; ex_rt = 5'd4;
    #2;
    chk("lu_done_pc_hold", 64'(pc_hold), 64'd0);
    chk("lu_fwd_a", 64'(fwd_a), 64'd2);
    chk("lu_fwd_b", 64'(fwd_b), 64'd0);
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd2);
    tick();

    // ---- redirect with a simultaneous load-use ----
    idle_inputs(); do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_waddr = 5'd3; id_rs = 5'd3; me_redirect = 1'b1;
    #2;
    chk("redir_pc_hold", 64'(pc_hold), 64'd0);
    chk("redir_ex_me_flush", 64'(ex_me_flush), 64'd1);
    tick();
    idle_inputs();
    #2;
    chk("redir_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("redir_stall_cnt", 64'(stall_cnt), 64'd0);

    // ---- halt: 4 drain cycles, halted on the 5th, release ----
    idle_inputs(); do_reset();
    halt_req = 1'b1;
    #2 chk("halt_run_pc_hold", 64'(pc_hold), 64'd0);
    tick();
    for (int i = 0; i < DRAIN_CYC; i++) begin
      #2;
      chk($sformatf("drain%0d_pc_hold", i), 64'(pc_hold), 64'd1);
      chk($sformatf("drain%0d_if_id_flush", i), 64'(if_id_flush), 64'd1);
      chk($sformatf("drain%0d_halted", i), 64'(halted), 64'd0);
      tick();
    end
    #2 chk("halted_set", 64'(halted), 64'd1);
    halt_req = 1'b0;
    tick();
    #2;
    chk("halt_release_halted", 64'(halted), 64'd0);
    chk("halt_release_pc_hold", 64'(pc_hold), 64'd0);

    // ---- saturation on the 4-bit instance, then reset mid-drain ----
    idle_inputs(); do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_waddr = 5'd6; id_rs = 5'd6;
    for (int i = 0; i < 20; i++) tick();
    #2;
    chk("sat_small_stall", 64'(s_stall_cnt), 64'd15);
    chk("sat_big_stall", 64'(stall_cnt), 64'd20);
    idle_inputs();
    halt_req = 1'b1;
    tick(); tick();
    #2 chk("mid_drain_pc_hold", 64'(pc_hold), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("arst_pc_hold", 64'(pc_hold), 64'd0);
    chk("arst_if_id_flush", 64'(if_id_flush), 64'd0);
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_small_stall", 64'(s_stall_cnt), 64'd0);
    halt_req = 1'b0;
    @(negedge clk); arst_n = 1'b1;
    tick();
    #2 chk("post_arst_run", 64'(pc_hold), 64'd0);

    // ---- randomized run against the model ----
    idle_inputs(); do_reset();
    for (int n = 0; n < 3000; n++) begin
      enable       = ($urandom_range(0, 15) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_rs        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      ex_reg_write = 1'($urandom_range(0, 1));
      ex_waddr     = 5'($urandom_range(0, 3));
      me_mem_read  = ($urandom_range(0, 3) == 0);
      me_reg_write = 1'($urandom_range(0, 1));
      me_waddr     = 5'($urandom_range(0, 3));
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_waddr     = 5'($urandom_range(0, 3));
      me_redirect  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      #2;
      check_model("rnd");
      @(posedge clk);
      model_clock();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
